// File: rtl/operand_capture.sv
// operand_capture: debounced key capture of two operands offered to an ALU via valid/ready
module operand_capture #(
  parameter int WIDTH   = 4,
  parameter int DEB_CNT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sw_in,
  input  logic [2:0]         key,
  input  logic               op_ready,
  output logic [WIDTH-1:0]   reg_a,
  output logic [WIDTH-1:0]   reg_b,
  output logic               a_loaded,
  output logic               b_loaded,
  output logic               op_valid,
  output logic [2*WIDTH-1:0] ind
);
  typedef enum logic {COLLECT, SEND} state_t;
  localparam logic [7:0] DMAX = 8'(DEB_CNT);
  localparam logic [7:0] DM1  = 8'(DEB_CNT - 1);
  state_t     state, state_n;
  logic [2:0] s1, s2, press;
  logic [7:0] cnt [3];
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      for (int i = 0; i < 3; i++) cnt[i] <= s2[i] ? ((cnt[i] == DMAX) ? cnt[i] : cnt[i] + 8'd1) : 8'd0;
    end
  end
  always_comb begin
    press = '0;
    for (int i = 0; i < 3; i++) press[i] = s2[i] && (cnt[i] == DM1);
  end
  always_comb begin
    state_n = (state == COLLECT) ? ((press[2] && a_loaded && b_loaded) ? SEND : COLLECT)
                                 : (op_ready ? COLLECT : SEND);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      op_valid <= 1'b0;
    end else begin
      state    <= state_n;
      op_valid <= (state_n == SEND);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a    <= '0;
      reg_b    <= '0;
      ind      <= '0;
      a_loaded <= 1'b0;
      b_loaded <= 1'b0;
    end else if (state == COLLECT) begin
      if (press[0]) begin
        reg_a    <= sw_in;
        a_loaded <= 1'b1;
      end
      if (press[1]) begin
        reg_b    <= sw_in;
        b_loaded <= 1'b1;
      end
      if (|press[1:0]) ind <= {{WIDTH{1'b0}}, sw_in};
    end else if (op_ready) begin
      a_loaded <= 1'b0;
      b_loaded <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_capture.sv
// tb_operand_capture: scoreboard bench for operand_capture (WIDTH=4, DEB_CNT=3)
module tb_operand_capture;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_in = '0;
  logic [2:0] key = '0;
  logic       op_ready = 1'b0;
  logic [3:0] reg_a, reg_b;
  logic       a_loaded, b_loaded, op_valid;
  logic [7:0] ind;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string      tag;
    logic [3:0] a, b;
    logic [7:0] ind;
    logic       al, bl, v;
  } exp_t;
  exp_t q[$];
  operand_capture #(.WIDTH(4), .DEB_CNT(3)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .key(key), .op_ready(op_ready),
    .reg_a(reg_a), .reg_b(reg_b), .a_loaded(a_loaded), .b_loaded(b_loaded),
    .op_valid(op_valid), .ind(ind)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_exp(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] i, input logic al, input logic bl, input logic v);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.ind = i; e.al = al; e.bl = bl; e.v = v;
    q.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, ".reg_a"}, 32'(reg_a), 32'(e.a));
      check({e.tag, ".reg_b"}, 32'(reg_b), 32'(e.b));
      check({e.tag, ".ind"}, 32'(ind), 32'(e.ind));
      check({e.tag, ".a_loaded"}, 32'(a_loaded), 32'(e.al));
      check({e.tag, ".b_loaded"}, 32'(b_loaded), 32'(e.bl));
      check({e.tag, ".op_valid"}, 32'(op_valid), 32'(e.v));
    end
  endtask
  task automatic press(input logic [2:0] mask, input logic [3:0] sw, input int hold);
    @(negedge clk);
    sw_in = sw;
    key = mask;
    repeat (hold) @(negedge clk);
    key = '0;
    repeat (6) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic latency(input string tag);
    repeat (4) @(posedge clk);
    #1 check({tag, ".early"}, 32'(a_loaded), 32'd0);
    @(posedge clk);
    #1 check({tag, ".on_time"}, 32'(a_loaded), 32'd1);
  endtask
  initial begin
    do_reset();
    @(negedge clk);
    push_exp("reset", 4'h0, 4'h0, 8'h00, 0, 0, 0);
    drain();
    sw_in = 4'h5;
    key = 3'b001;
    latency("lat_a");
    @(negedge clk);
    sw_in = 4'h6;
    repeat (4) @(negedge clk);
    key = '0;
    repeat (6) @(negedge clk);
    push_exp("hold_a", 4'h5, 4'h0, 8'h05, 1, 0, 0);
    drain();
    do_reset();
    press(3'b001, 4'h9, 2);
    push_exp("glitch", 4'h0, 4'h0, 8'h00, 0, 0, 0);
    drain();
    press(3'b011, 4'hC, 6);
    push_exp("both", 4'hC, 4'hC, 8'h0C, 1, 1, 0);
    drain();
    @(negedge clk);
    op_ready = 1'b1;
    repeat (3) @(negedge clk);
    op_ready = 1'b0;
    push_exp("ready_collect", 4'hC, 4'hC, 8'h0C, 1, 1, 0);
    drain();
    do_reset();
    press(3'b001, 4'h3, 6);
    press(3'b100, 4'h0, 6);
    push_exp("submit_a_only", 4'h3, 4'h0, 8'h03, 1, 0, 0);
    drain();
    press(3'b110, 4'h7, 6);
    push_exp("load_b_with_submit", 4'h3, 4'h7, 8'h07, 1, 1, 0);
    drain();
    press(3'b100, 4'h0, 6);
    push_exp("submit", 4'h3, 4'h7, 8'h07, 1, 1, 1);
    drain();
    repeat (5) @(negedge clk);
    push_exp("wait_ready", 4'h3, 4'h7, 8'h07, 1, 1, 1);
    drain();
    press(3'b011, 4'h1, 6);
    push_exp("frozen", 4'h3, 4'h7, 8'h07, 1, 1, 1);
    drain();
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    push_exp("handshake", 4'h3, 4'h7, 8'h07, 0, 0, 0);
    drain();
    press(3'b011, 4'h2, 6);
    press(3'b100, 4'h0, 6);
    push_exp("resubmit", 4'h2, 4'h2, 8'h02, 1, 1, 1);
    drain();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_exp("reset_in_send", 4'h0, 4'h0, 8'h00, 0, 0, 0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    sw_in = 4'h5;
    key = 3'b001;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    latency("lat_rst");
    repeat (6) @(negedge clk);
    key = '0;
    repeat (6) @(negedge clk);
    push_exp("held_through_rst", 4'h5, 4'h0, 8'h05, 1, 0, 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
